// File: rtl/pipe_reg_pkg.sv
// Shared defaults and helpers for the handshaked register pipeline.
package pipe_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit plus a data register with load, hold and clear.
module pipe_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Data only captures when a real item arrives, so bubbles never disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// Elastic register pipeline with valid/ready handshake and bubble collapsing.
// Define PIPE_REG_OCC_EN to add the occ occupancy counter port.
module pipe_reg_hs
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  logic [DEPTH:0]   v_chain;
  logic [WIDTH-1:0] d_chain [DEPTH+1];
  logic [DEPTH-1:0] rdy;
  logic             adv;

  assign v_chain[0] = in_valid;
  assign d_chain[0] = in_data;
  assign adv        = en & ~flush;

  // A stage can take new contents if it is empty or its own contents move on.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v_chain[DEPTH] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = ~v_chain[i+1] | rdy[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (adv & rdy[g]),
      .in_valid(v_chain[g]),
      .in_data (d_chain[g]),
      .valid   (v_chain[g+1]),
      .data    (d_chain[g+1])
    );
  end

  assign in_ready  = adv & rdy[0];
  assign out_valid = en & v_chain[DEPTH];
  assign out_data  = d_chain[DEPTH];

`ifdef PIPE_REG_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Simultaneous in and out transfers leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ <= occ + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ <= occ - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Self-checking bench for pipe_reg_hs: queue-of-positions model plus directed scenarios.
module tb_pipe_reg_hs;
  import pipe_reg_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;

  logic         in_valid1;
  logic [W-1:0] in_data1;
  logic         out_ready1;
  logic         in_ready1;
  logic         out_valid1;
  logic [W-1:0] out_data1;

`ifdef PIPE_REG_OCC_EN
  logic [occ_width(D)-1:0] occ;
  logic [occ_width(1)-1:0] occ1;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_reg_hs #(
    .WIDTH(W),
    .DEPTH(D)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef PIPE_REG_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  pipe_reg_hs #(
    .WIDTH(W),
    .DEPTH(1)
  ) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid1),
    .in_data  (in_data1),
    .in_ready (in_ready1),
    .out_valid(out_valid1),
    .out_data (out_data1),
    .out_ready(out_ready1)
`ifdef PIPE_REG_OCC_EN
    ,
    .occ      (occ1)
`endif
  );

  always #5 clk = ~clk;

  // Model: each item in flight is a (stage position, data) pair, oldest first.
  int           m_pos[$];
  logic [W-1:0] m_dat[$];
  logic [W-1:0] m_last;
  bit           model_on = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Oldest item leaves from the last slot or moves up one slot if the slot ahead ends up free.
  function automatic void plan(input bit ordy, output int np[$]);
    int lim;
    np  = {};
    lim = D;
    for (int k = 0; k < m_pos.size(); k++) begin
      int p;
      p = m_pos[k];
      if (p == D - 1) begin
        if (ordy) p = D;
      end else if (p + 1 < lim) begin
        p = p + 1;
      end
      np.push_back(p);
      lim = p;
    end
  endfunction

  function automatic bit model_in_ready();
    int np[$];
    if (!en || flush) return 1'b0;
    plan(out_ready, np);
    return (np.size() == 0) || (np[np.size()-1] > 0);
  endfunction

  function automatic bit model_out_valid();
    return en && (m_pos.size() > 0) && (m_pos[0] == D - 1);
  endfunction

  always @(posedge clk) begin
    bit           acc;
    int           np[$];
    int           nq_pos[$];
    logic [W-1:0] nq_dat[$];
    if (reset) begin
      m_pos    = {};
      m_dat    = {};
      m_last   = '0;
      model_on = 1'b1;
    end else if (flush) begin
      m_pos = {};
      m_dat = {};
    end else if (en) begin
      acc    = in_valid && model_in_ready();
      nq_pos = {};
      nq_dat = {};
      plan(out_ready, np);
      for (int k = 0; k < np.size(); k++) begin
        if (np[k] < D) begin
          nq_pos.push_back(np[k]);
          nq_dat.push_back(m_dat[k]);
          if (np[k] == D - 1 && m_pos[k] != D - 1) m_last = m_dat[k];
        end
      end
      if (acc) begin
        nq_pos.push_back(0);
        nq_dat.push_back(in_data);
        if (D == 1) m_last = in_data;
      end
      m_pos = nq_pos;
      m_dat = nq_dat;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_in_ready", 32'(in_ready), 32'(model_in_ready()));
      checkOutput("model_out_valid", 32'(out_valid), 32'(model_out_valid()));
      checkOutput("model_out_data", 32'(out_data), 32'(m_last));
`ifdef PIPE_REG_OCC_EN
      checkOutput("model_occ", 32'(occ), 32'(m_pos.size()));
`endif
    end
  end

  task automatic applyStimulus(input bit r, input bit e, input bit f, input bit iv,
                               input logic [W-1:0] id, input bit ordy);
    @(posedge clk);
    #1;
    reset      = r;
    en         = e;
    flush      = f;
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b0;
    #2;
  endtask

  task automatic applyStimulus1(input bit iv1, input logic [W-1:0] id1, input bit ordy1);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    en         = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    in_valid1  = iv1;
    in_data1   = id1;
    out_ready1 = ordy1;
    #2;
  endtask

  initial begin
    int           nxt;
    int           c;
    int           seen;
    logic [W-1:0] got[$];

    reset      = 1'b1;
    en         = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b0;

    // Reset state
    applyStimulus(1, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
`ifdef PIPE_REG_OCC_EN
    checkOutput("rst_occ", 32'(occ), 0);
`endif

    // Latency: single item appears exactly DEPTH cycles after acceptance
    applyStimulus(0, 1, 0, 1, 8'hA5, 1);
    checkOutput("lat_accept", 32'(in_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
      if (k == 4) begin
        checkOutput("lat_out_valid", 32'(out_valid), 1);
        checkOutput("lat_out_data", 32'(out_data), 32'hA5);
      end else begin
        checkOutput($sformatf("lat_idle%0d", k), 32'(out_valid), 0);
      end
    end

    // Backpressure: four accepts fill the pipe, then release and drain in order
    nxt = 1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 0, 1, 8'(nxt), 0);
      if (in_ready) nxt++;
    end
    checkOutput("bp_accepts", 32'(nxt - 1), 4);
    checkOutput("bp_stall_in_ready", 32'(in_ready), 0);
    checkOutput("bp_head_data", 32'(out_data), 1);
    checkOutput("bp_model_occ", 32'(m_pos.size()), 4);
`ifdef PIPE_REG_OCC_EN
    checkOutput("bp_occ", 32'(occ), 4);
`endif
    got = {};
    c   = 0;
    while (got.size() < 6 && c < 30) begin
      applyStimulus(0, 1, 0, nxt <= 6, 8'(nxt), 1);
      if (in_valid && in_ready) nxt++;
      if (out_valid) got.push_back(out_data);
      c++;
    end
    checkOutput("bp_count", 32'(got.size()), 6);
    for (int k = 0; k < got.size(); k++) begin
      checkOutput($sformatf("bp_order%0d", k), 32'(got[k]), 32'(k + 1));
    end

    // Enable freeze mid-stream
    got = {};
    c   = 0;
    nxt = 8'h10;
    while (got.size() < 6 && c < 40) begin
      bit e;
      e = !(c >= 3 && c < 6);
      applyStimulus(0, e, 0, nxt <= 8'h15, 8'(nxt), 1);
      if (!e) begin
        checkOutput($sformatf("freeze_in_ready%0d", c), 32'(in_ready), 0);
        checkOutput($sformatf("freeze_out_valid%0d", c), 32'(out_valid), 0);
      end
      if (in_valid && in_ready) nxt++;
      if (out_valid) got.push_back(out_data);
      c++;
    end
    checkOutput("freeze_count", 32'(got.size()), 6);
    for (int k = 0; k < got.size(); k++) begin
      checkOutput($sformatf("freeze_order%0d", k), 32'(got[k]), 32'(8'h10 + k));
    end

    // Flush with three items held and a new input offered
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 1, 8'(8'h20 + k), 0);
    end
    applyStimulus(0, 1, 1, 1, 8'h23, 0);
    checkOutput("flush_in_ready", 32'(in_ready), 0);
    checkOutput("flush_model_occ", 32'(m_pos.size()), 3);
`ifdef PIPE_REG_OCC_EN
    checkOutput("flush_occ_before", 32'(occ), 3);
`endif
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    checkOutput("flush_out_valid", 32'(out_valid), 0);
    checkOutput("flush_model_empty", 32'(m_pos.size()), 0);
`ifdef PIPE_REG_OCC_EN
    checkOutput("flush_occ_after", 32'(occ), 0);
`endif
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
      if (out_valid) seen++;
    end
    checkOutput("flush_no_output", 32'(seen), 0);

    // Reset with a full pipe and live handshake inputs
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, 1, 8'(8'h30 + k), 0);
    end
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    checkOutput("full_out_valid", 32'(out_valid), 1);
    checkOutput("full_out_data", 32'(out_data), 32'h30);
    checkOutput("full_in_ready", 32'(in_ready), 0);
    applyStimulus(1, 1, 0, 1, 8'h99, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    checkOutput("rst2_out_valid", 32'(out_valid), 0);
    checkOutput("rst2_out_data", 32'(out_data), 0);
    checkOutput("rst2_in_ready", 32'(in_ready), 1);
`ifdef PIPE_REG_OCC_EN
    checkOutput("rst2_occ", 32'(occ), 0);
`endif

    // DEPTH=1: one transfer per cycle, latency one
    for (int k = 0; k < 8; k++) begin
      applyStimulus1(1, 8'(8'h40 + k), 1);
      checkOutput($sformatf("d1_in_ready%0d", k), 32'(in_ready1), 1);
      if (k == 0) begin
        checkOutput("d1_first_out_valid", 32'(out_valid1), 0);
      end else begin
        checkOutput($sformatf("d1_out_valid%0d", k), 32'(out_valid1), 1);
        checkOutput($sformatf("d1_out_data%0d", k), 32'(out_data1), 32'(8'h40 + k - 1));
      end
    end
    applyStimulus1(1, 8'h50, 0);
    checkOutput("d1_stall_in_ready", 32'(in_ready1), 0);
    applyStimulus1(0, 8'h00, 0);
    checkOutput("d1_hold_out_valid", 32'(out_valid1), 1);
    checkOutput("d1_hold_out_data", 32'(out_data1), 32'h47);
`ifdef PIPE_REG_OCC_EN
    checkOutput("d1_occ", 32'(occ1), 1);
`endif
    applyStimulus1(0, 8'h00, 1);
    applyStimulus1(0, 8'h00, 1);
    checkOutput("d1_drained", 32'(out_valid1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_reg_hs.md
PIPE_REG_HS -- requirements
Module: pipe_reg_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (legal ≥1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal ≥1).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, global advance enable; 0 = freeze all state.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all stage valid bits.
REQ-007 SHALL have port in_valid, input, 1, upstream data valid.
REQ-008 SHALL have port in_data, input, WIDTH, upstream data.
REQ-009 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-010 SHALL have port out_valid, output, 1, out_data valid.
REQ-011 SHALL have port out_data, output, WIDTH, data of last stage.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-013 SHALL have port occ, output, $clog2(DEPTH+1), count of valid stages (only when PIPE_REG_OCC_EN defined).

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) one valid bit v[i] and one WIDTH-bit data register d[i]; stage 0 is input side.
REQ-015 SHALL transfer in on a cycle where in_valid & in_ready, and out on a cycle where out_valid & out_ready.
REQ-016 SHALL define stage-ready: rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready; rdy[i] = ~v[i] | rdy[i+1]; in_ready = en & ~flush & rdy[0].
REQ-017 SHALL, when en=1 and flush=0 and rdy[i]=1, load stage i from stage i-1 (stage 0 from in_valid/in_data); otherwise stage i holds.
REQ-018 SHALL drive out_valid = en & v[DEPTH-1] and out_data = d[DEPTH-1]; out_valid SHALL NOT depend combinationally on in_valid.
REQ-019 SHALL collapse bubbles: an empty stage is filled even while out_ready=0.
REQ-020 SHALL give latency DEPTH cycles from an accepted input to out_valid on an empty pipe with en=1, out_ready=1.
REQ-021 SHALL sustain one transfer per cycle when full with out_ready=1 and in_valid=1.
REQ-022 SHALL, when full and out_ready=0, drive in_ready=0 and hold every stage unchanged.
REQ-023 SHALL, when en=0, hold all v[i] and d[i], drive in_ready=0 and out_valid=0.
REQ-024 SHALL, on flush=1 at an edge, clear all v[i] (data may keep value); flush SHALL override en, in_valid and out_ready; in_ready=0 during flush cycle.
REQ-025 SHALL leave data registers unchanged when the corresponding stage does not load (no spurious capture of in_data when in_valid=0; v[0] loads 0).
REQ-026 SHALL behave identically for DEPTH=1 using the same rules (in_ready = en & ~flush & (~v[0] | out_ready)).

Reset
REQ-027 SHALL on reset=1 at a rising clk edge clear all v[i] to 0 and all d[i] to 0; reset SHALL override flush and en.
REQ-028 SHALL after reset present out_valid=0, out_data=0, occ=0, in_ready=en & ~flush.
REQ-029 SHALL discard in-flight data when reset asserts mid-stream; no transfer completes on that edge.

Configuration
REQ-030 SHALL, with macro PIPE_REG_OCC_EN defined, provide port occ: +1 on input transfer, -1 on output transfer, unchanged when both or neither, 0 on flush or reset; range 0..DEPTH.
REQ-031 SHALL, without PIPE_REG_OCC_EN, omit port occ and its counter entirely; all other behaviour identical.

Structure
REQ-032 SHALL place default WIDTH/DEPTH constants and the occ-width function (ceil log2 of DEPTH+1) in shared package pipe_reg_pkg.
REQ-033 SHALL implement each stage as sub-module pipe_stage (valid+data register with load/hold/clear), instantiated DEPTH times by generate loop.

Verification
REQ-034 Reset: reset=1 one cycle with pipe full -> out_valid=0, out_data=0, occ=0 next cycle.
REQ-035 Latency: DEPTH=4, WIDTH=8, en=1, out_ready=1, send 0xA5 once -> out_valid=1, out_data=0xA5 exactly 4 cycles later, one cycle only.
REQ-036 Backpressure: stream 0x01..0x06, out_ready=0 -> in_ready=0 after 4 accepts, occ=4; release out_ready -> out_data 0x01..0x06 in order, no loss/duplication.
REQ-037 Enable freeze: en=0 for 3 cycles mid-stream -> in_ready=0, out_valid=0, contents and occ unchanged; resume yields same order.
REQ-038 Flush: flush=1 with occ=3 and in_valid=1 -> next cycle all invalid, occ=0, flushed input not accepted.
REQ-039 DEPTH=1, continuous in_valid and out_ready -> one transfer per cycle, latency 1.
